// File: rtl/bus_trace_pkg.sv
// Shared types and record-layout helpers for the 386SX bus-cycle tracer.
// Record layout, LSB first: data, address, be_b, control, timestamp, ovf.
package bus_trace_pkg;

   localparam int CTRL_W = 3;
   localparam int BE_W   = 2;

   // {M/IO#, D/C#, W/R#} as presented by the CPU
   typedef enum logic [2:0] {
      INT_ACK = 3'b000,
      UNDEF   = 3'b001,
      IO_RD   = 3'b010,
      IO_WR   = 3'b011,
      CODE_RD = 3'b100,
      HALT    = 3'b101,
      MEM_RD  = 3'b110,
      MEM_WR  = 3'b111
   } bus_class_e;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} ser_state_e;

   typedef enum int {F_DATA, F_ADDR, F_BE, F_CTRL, F_TS, F_OVF} rec_field_e;

   function automatic int fld_off(rec_field_e f, int addr_w, int data_w, int ts_w);
      int off;
      off = 0;
      if (f > F_DATA) off += data_w;
      if (f > F_ADDR) off += addr_w;
      if (f > F_BE)   off += BE_W;
      if (f > F_CTRL) off += CTRL_W;
      if (f > F_TS)   off += ts_w;
      return off;
   endfunction

   function automatic int rec_w(int addr_w, int data_w, int ts_w);
      return fld_off(F_OVF, addr_w, data_w, ts_w) + 1;
   endfunction

   function automatic int bpl(int rw, int lanes);
      return (rw + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; a push is accepted at full when a pop happens on
// the same edge, and a pop at empty is ignored.
module trace_fifo #(
   parameter int W     = 62,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk2x,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   level_q;
   logic          do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign level_o = level_q;
   assign rdata_o = mem_q[rp_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk2x or negedge reset_n) begin
      if (!reset_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk2x) begin
      if (do_push) mem_q[wp_q] <= wdata_i;
   end

endmodule

// File: rtl/bus_trace_capture.sv
// 386SX bus-cycle tracer: two-slot pipelined-address tracker, class filter,
// overflow accounting, record FIFO and multi-lane serial streamer.
module bus_trace_capture
   import bus_trace_pkg::*;
#(
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 16,
   parameter int TS_W     = 16,
   parameter int DEPTH    = 16,
   parameter int LANES    = 5,
   parameter int SCLK_DIV = 2
) (
   input  logic                     clk2x,
   input  logic                     reset_n,
   input  logic                     arm,
   input  logic [7:0]               capture_mask,
   input  logic                     ads_b,
   input  logic                     ready_b,
   input  logic [ADDR_W-1:0]        address_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic [1:0]               be_b,
   input  logic [2:0]               control,
   output logic                     sclk,
   output logic                     cs_n,
   output logic [LANES-1:0]         sout,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               overflow_cnt,
   output logic                     protocol_err
);

   localparam int REC_W    = rec_w(ADDR_W, DATA_W, TS_W);
   localparam int BPL      = bpl(REC_W, LANES);
   localparam int OFF_ADDR = fld_off(F_ADDR, ADDR_W, DATA_W, TS_W);
   localparam int OFF_BE   = fld_off(F_BE,   ADDR_W, DATA_W, TS_W);
   localparam int OFF_CTRL = fld_off(F_CTRL, ADDR_W, DATA_W, TS_W);
   localparam int OFF_TS   = fld_off(F_TS,   ADDR_W, DATA_W, TS_W);
   localparam int OFF_OVF  = fld_off(F_OVF,  ADDR_W, DATA_W, TS_W);
   localparam int PER      = 2 * SCLK_DIV;
   localparam int PW       = $clog2(PER);
   localparam int BW       = $clog2(BPL + 1);

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        be;
      bus_class_e        ctrl;
      logic [TS_W-1:0]   ts;
   } slot_t;

   logic [TS_W-1:0]  ts_q;
   slot_t            cur_q, cur_d, pend_q, pend_d, new_slot;
   logic             proto_q, proto_d;
   logic             retire, ads_hit;
   logic             push_q, push_d;
   logic [REC_W-1:0] rec_q, rec_d, wdata;
   logic             drop, drop_flag_q, drop_flag_d;
   logic [7:0]       ovf_cnt_q, ovf_cnt_d;

   logic [REC_W-1:0]           rdata;
   logic                       fifo_full, fifo_empty, pop;
   logic [LANES*BPL-1:0]       padded;
   ser_state_e                 state_q, state_d;
   logic [PW-1:0]              ph_q;
   logic [BW-1:0]              bit_q;
   logic [LANES-1:0][BPL-1:0]  lanes_q;
   logic                       ph_last, bit_last;

   // Retire happens before the new ADS is placed, so a same-edge ADS sees
   // the slots as they are after promotion.
   always_comb begin
      new_slot      = '0;
      new_slot.v    = 1'b1;
      new_slot.addr = address_i;
      new_slot.be   = be_b;
      new_slot.ctrl = bus_class_e'(control);
      new_slot.ts   = ts_q;
      retire  = !ready_b && cur_q.v;
      ads_hit = !ads_b && arm;
      cur_d   = cur_q;
      pend_d  = pend_q;
      proto_d = proto_q;
      if (retire) begin
         cur_d  = pend_q;
         pend_d = '0;
      end
      if (ads_hit) begin
         if (!cur_d.v)       cur_d   = new_slot;
         else if (!pend_d.v) pend_d  = new_slot;
         else                proto_d = 1'b1;
      end
   end

   always_comb begin
      push_d = retire && capture_mask[cur_q.ctrl];
      rec_d  = '0;
      rec_d[DATA_W-1:0]           = data_i;
      rec_d[OFF_ADDR +: ADDR_W]   = cur_q.addr;
      rec_d[OFF_BE +: BE_W]       = cur_q.be;
      rec_d[OFF_CTRL +: CTRL_W]   = cur_q.ctrl;
      rec_d[OFF_TS +: TS_W]       = cur_q.ts;
      wdata          = rec_q;
      wdata[OFF_OVF] = drop_flag_q;
   end

   always_comb begin
      drop        = push_q && fifo_full && !pop;
      drop_flag_d = drop_flag_q;
      ovf_cnt_d   = ovf_cnt_q;
      if (drop) begin
         drop_flag_d = 1'b1;
         if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 1'b1;
      end else if (push_q) begin
         drop_flag_d = 1'b0;
      end
   end

   always_ff @(posedge clk2x or negedge reset_n) begin
      if (!reset_n) begin
         ts_q        <= '0;
         cur_q       <= '0;
         pend_q      <= '0;
         proto_q     <= 1'b0;
         push_q      <= 1'b0;
         rec_q       <= '0;
         drop_flag_q <= 1'b0;
         ovf_cnt_q   <= '0;
      end else begin
         ts_q        <= ts_q + 1'b1;
         cur_q       <= cur_d;
         pend_q      <= pend_d;
         proto_q     <= proto_d;
         push_q      <= push_d;
         rec_q       <= rec_d;
         drop_flag_q <= drop_flag_d;
         ovf_cnt_q   <= ovf_cnt_d;
      end
   end

   trace_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk2x   (clk2x),
      .reset_n (reset_n),
      .push_i  (push_q),
      .wdata_i (wdata),
      .pop_i   (pop),
      .rdata_o (rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign overflow_cnt = ovf_cnt_q;
   assign protocol_err = proto_q;

   assign ph_last  = (ph_q == PW'(PER - 1));
   assign bit_last = (bit_q == BW'(BPL - 1));

   always_ff @(posedge clk2x or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: if (bit_last && ph_last) state_d = S_GAP;
         S_GAP:   if (ph_last) state_d = fifo_empty ? S_IDLE : S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop  = (state_q == S_LOAD);
      cs_n = (state_q != S_SHIFT);
      sclk = (state_q == S_SHIFT) && (ph_q >= PW'(SCLK_DIV));
      for (int k = 0; k < LANES; k++)
         sout[k] = (state_q == S_SHIFT) && lanes_q[k][BPL-1];
   end

   always_comb begin
      padded              = '0;
      padded[REC_W-1:0]   = rdata;
   end

   always_ff @(posedge clk2x or negedge reset_n) begin
      if (!reset_n) begin
         ph_q    <= '0;
         bit_q   <= '0;
         lanes_q <= '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               lanes_q <= padded;
               ph_q    <= '0;
               bit_q   <= '0;
            end
            S_SHIFT: begin
               ph_q <= ph_last ? '0 : ph_q + 1'b1;
               if (ph_last) begin
                  bit_q <= bit_q + 1'b1;
                  for (int k = 0; k < LANES; k++) lanes_q[k] <= lanes_q[k] << 1;
               end
            end
            S_GAP:   ph_q <= ph_last ? '0 : ph_q + 1'b1;
            default: ph_q <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_trace_capture.sv
// Bench for bus_trace_capture: directed table, hand sequences and random bus
// traffic, with serial frames decoded back into records and compared in order.
module tb_bus_trace_capture;

   localparam int ADDR_W = 24, DATA_W = 16, TS_W = 16, DEPTH = 16, LANES = 5, SCLK_DIV = 2;
   localparam int REC_W  = 1 + TS_W + 3 + 2 + ADDR_W + DATA_W;
   localparam int BPL    = (REC_W + LANES - 1) / LANES;
   localparam int FRAME  = BPL * 2 * SCLK_DIV;

   logic clk2x = 1'b0, reset_n = 1'b0, arm = 1'b0;
   logic [7:0] capture_mask = 8'hFF;
   logic ads_b = 1'b1, ready_b = 1'b1;
   logic [ADDR_W-1:0] address_i = '0;
   logic [DATA_W-1:0] data_i = '0;
   logic [1:0] be_b = '0;
   logic [2:0] control = '0;
   logic sclk, cs_n;
   logic [LANES-1:0] sout;
   logic [$clog2(DEPTH):0] fifo_level;
   logic [7:0] overflow_cnt;
   logic protocol_err;

   bus_trace_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH),
                       .LANES(LANES), .SCLK_DIV(SCLK_DIV)) dut (
      .clk2x(clk2x), .reset_n(reset_n), .arm(arm), .capture_mask(capture_mask),
      .ads_b(ads_b), .ready_b(ready_b), .address_i(address_i), .data_i(data_i),
      .be_b(be_b), .control(control), .sclk(sclk), .cs_n(cs_n), .sout(sout),
      .fifo_level(fifo_level), .overflow_cnt(overflow_cnt), .protocol_err(protocol_err)
   );

   always #5 clk2x = ~clk2x;

   typedef struct {
      logic [2:0]        c;
      logic [ADDR_W-1:0] a;
      logic [1:0]        be;
      logic [DATA_W-1:0] d;
      logic [TS_W-1:0]   ts;
   } cyc_t;

   typedef struct {
      logic [2:0] c;
      logic [7:0] mask;
      bit         arm_ads;
      bit         arm_rdy;
      int         n_exp;
   } vec_t;

   int checks = 0, failures = 0;
   logic [REC_W-1:0] expq[$], rxq[$];
   int unsigned cyc;

   // Edges seen since reset release: the value the timestamp must carry.
   always @(posedge clk2x or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Serial receiver: sample each lane at sclk rise while the frame is open.
   logic [BPL-1:0]       rx_l [LANES];
   logic [LANES*BPL-1:0] rx_pad;
   int rx_n = 0;
   always @(posedge sclk or negedge reset_n) begin
      if (!reset_n) rx_n = 0;
      else if (!cs_n) begin
         for (int k = 0; k < LANES; k++) rx_l[k] = {rx_l[k][BPL-2:0], sout[k]};
         rx_n++;
         if (rx_n == BPL) begin
            for (int k = 0; k < LANES; k++) rx_pad[k*BPL +: BPL] = rx_l[k];
            chk("pad_bits", 64'(rx_pad >> REC_W), 0);
            rxq.push_back(rx_pad[REC_W-1:0]);
            rx_n = 0;
         end
      end
   end

   int lowcnt = 0;
   always @(negedge clk2x) begin
      if (!reset_n) lowcnt = 0;
      else if (!cs_n) lowcnt++;
      else if (lowcnt != 0) begin
         chk("frame_len", lowcnt, FRAME);
         lowcnt = 0;
      end
   end

   function automatic cyc_t rnd_cyc(input logic [2:0] c);
      cyc_t x;
      x.c = c; x.a = ADDR_W'($urandom); x.be = 2'($urandom);
      x.d = DATA_W'($urandom); x.ts = '0;
      return x;
   endfunction

   function automatic logic [REC_W-1:0] mk_rec(input bit ovf, input cyc_t x);
      return {ovf, x.ts, x.c, x.be, x.a, x.d};
   endfunction

   // Reference rule: a retired cycle is recorded iff its class is enabled.
   function automatic void mdl_push(input cyc_t x, input bit ovf);
      if (capture_mask[x.c]) expq.push_back(mk_rec(ovf, x));
   endfunction

   // One clock of bus activity, starting and ending on a falling edge.
   task automatic drv(input bit a, inout cyc_t x, input bit r, input logic [DATA_W-1:0] d);
      ads_b = !a; ready_b = !r;
      if (a) begin
         control = x.c; address_i = x.a; be_b = x.be; x.ts = TS_W'(cyc);
      end else begin
         control = 3'($urandom); address_i = ADDR_W'($urandom); be_b = 2'($urandom);
      end
      data_i = r ? d : DATA_W'($urandom);
      @(negedge clk2x);
   endtask

   task automatic idle(input int n);
      cyc_t nx;
      nx = rnd_cyc(3'd0);
      repeat (n) drv(0, nx, 0, '0);
   endtask

   task automatic seq_single(inout cyc_t x, input int ws);
      cyc_t nx;
      nx = rnd_cyc(3'd0);
      drv(1, x, 0, '0);
      repeat (ws) drv(0, nx, 0, '0);
      drv(0, nx, 1, x.d);
      idle(1);
   endtask

   task automatic seq_pipe(inout cyc_t x, inout cyc_t y);
      cyc_t nx;
      nx = rnd_cyc(3'd0);
      drv(1, x, 0, '0);
      drv(1, y, 0, '0);
      drv(0, nx, 1, x.d);
      drv(0, nx, 1, y.d);
      idle(1);
   endtask

   task automatic seq_overlap(inout cyc_t x, inout cyc_t y);
      cyc_t nx;
      nx = rnd_cyc(3'd0);
      drv(1, x, 0, '0);
      drv(1, y, 1, x.d);
      drv(0, nx, 1, y.d);
      idle(1);
   endtask

   // Back-to-back: every edge retires one cycle and issues the next.
   task automatic chain(input int n, input int keep);
      cyc_t p, q;
      p = rnd_cyc(3'($urandom));
      drv(1, p, 0, '0);
      for (int i = 0; i < n; i++) begin
         q = rnd_cyc(3'($urandom));
         drv(i < n - 1, q, 1, p.d);
         if (i < keep) mdl_push(p, 1'b0);
         p = q;
      end
      idle(1);
   endtask

   task automatic wait_idle();
      int quiet;
      quiet = 0;
      for (int i = 0; i < 4000 && quiet < 8; i++) begin
         @(negedge clk2x);
         if (cs_n && fifo_level == 0) quiet++;
         else quiet = 0;
      end
      chk("drain_done", quiet >= 8, 1);
   endtask

   task automatic wait_cond(input string nm, input bit want_frame);
      int i;
      for (i = 0; i < 400; i++) begin
         if (want_frame ? !cs_n : (fifo_level < DEPTH)) break;
         @(negedge clk2x);
      end
      chk(nm, i < 400, 1);
   endtask

   task automatic cmp_q(input string nm);
      chk({nm, "_count"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++) chk(nm, rxq[i], expq[i]);
      rxq.delete();
      expq.delete();
   endtask

   vec_t tbl[12];

   initial begin
      cyc_t x, y, z;
      int n0;

      for (int i = 0; i < 8; i++) tbl[i] = '{3'(i), 8'h40, 1'b1, 1'b1, (i == 6)};
      tbl[8]  = '{3'b000, 8'h01, 1'b1, 1'b1, 1};
      tbl[9]  = '{3'b111, 8'h7F, 1'b1, 1'b1, 0};
      tbl[10] = '{3'b010, 8'hFF, 1'b0, 1'b1, 0};
      tbl[11] = '{3'b011, 8'hFF, 1'b1, 1'b0, 1};

      repeat (3) @(negedge clk2x);
      chk("rst_sclk", sclk, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sout", sout, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ovf", overflow_cnt, 0);
      chk("rst_perr", protocol_err, 0);
      reset_n = 1'b1; arm = 1'b1;
      idle(2);

      x = '{3'b111, 24'h0BEBE0, 2'b00, 16'h1234, 16'h0};
      seq_single(x, 0);
      mdl_push(x, 1'b0);
      chk("level_after_push", fifo_level, 1);
      wait_idle();
      cmp_q("single");

      x = rnd_cyc(3'b110); y = rnd_cyc(3'b111);
      seq_pipe(x, y);
      mdl_push(x, 1'b0); mdl_push(y, 1'b0);
      chk("perr_pipe", protocol_err, 0);
      x = rnd_cyc(3'b010); y = rnd_cyc(3'b011); z = rnd_cyc(3'b111);
      drv(1, x, 0, '0); drv(1, y, 0, '0); drv(1, z, 0, '0);
      drv(0, z, 1, x.d); drv(0, z, 1, y.d); idle(1);
      mdl_push(x, 1'b0); mdl_push(y, 1'b0);
      chk("perr_third", protocol_err, 1);
      wait_idle();
      cmp_q("pipe");

      foreach (tbl[i]) begin
         n0 = rxq.size();
         capture_mask = tbl[i].mask;
         x = rnd_cyc(tbl[i].c);
         arm = tbl[i].arm_ads;
         drv(1, x, 0, '0);
         arm = tbl[i].arm_rdy;
         drv(0, y, 1, x.d);
         idle(1);
         arm = 1'b1;
         wait_idle();
         chk("tbl_frames", rxq.size() - n0, tbl[i].n_exp);
         if (tbl[i].n_exp != 0) expq.push_back(mk_rec(1'b0, x));
      end
      cmp_q("tbl");

      for (int r = 0; r < 6; r++) begin
         capture_mask = 8'($urandom);
         for (int s = 0; s < 5; s++) begin
            x = rnd_cyc(3'($urandom)); y = rnd_cyc(3'($urandom));
            case ($urandom_range(0, 2))
               0: begin seq_single(x, int'($urandom_range(0, 3))); mdl_push(x, 1'b0); end
               1: begin seq_pipe(x, y); mdl_push(x, 1'b0); mdl_push(y, 1'b0); end
               default: begin seq_overlap(x, y); mdl_push(x, 1'b0); mdl_push(y, 1'b0); end
            endcase
            idle(int'($urandom_range(0, 4)));
         end
         wait_idle();
         cmp_q("rand");
      end

      capture_mask = 8'hFF;
      x = rnd_cyc(3'b111);
      seq_single(x, 1);
      mdl_push(x, 1'b0);
      wait_cond("frame_start", 1'b1);
      chain(DEPTH + 3, DEPTH);
      idle(2);
      chk("ovf_level", fifo_level, DEPTH);
      chk("ovf_cnt3", overflow_cnt, 3);
      wait_cond("slot_free1", 1'b0);
      x = rnd_cyc(3'b110);
      seq_single(x, 0);
      mdl_push(x, 1'b1);
      wait_cond("slot_free2", 1'b0);
      x = rnd_cyc(3'b101);
      seq_single(x, 0);
      mdl_push(x, 1'b0);
      chk("ovf_cnt_hold", overflow_cnt, 3);
      wait_idle();
      cmp_q("ovf");

      chain(320, 0);
      idle(2);
      chk("ovf_sat", overflow_cnt, 255);
      expq.delete();

      wait_cond("frame_mid", 1'b1);
      idle(10);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_cs_n", cs_n, 1);
      chk("mid_sclk", sclk, 0);
      chk("mid_sout", sout, 0);
      chk("mid_level", fifo_level, 0);
      chk("mid_ovf", overflow_cnt, 0);
      chk("mid_perr", protocol_err, 0);
      repeat (3) @(negedge clk2x);
      reset_n = 1'b1;
      rxq.delete();
      idle(3);
      x = rnd_cyc(3'b111);
      seq_single(x, 2);
      mdl_push(x, 1'b0);
      wait_idle();
      cmp_q("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
